mips_multicycle_ctrl: RTL

//  Main control FSM for the multicycle MIPS datapath. Decodes the latched opcode and

---
 rtl/mips_multicycle_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: fetch/decode/execute sequencing,
// memory req/ready handshake with timeout, sticky fault. Define CTRL_ZERO_EXT_EN for andi/ori.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_bz,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] ext_sel,
  output logic       fault,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_JMP    = 4'd9,
    S_IEX    = 4'd10,
    S_IWB    = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef CTRL_ZERO_EXT_EN
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             fault_q;

  logic             funct_ok;
  logic             zext_op;
  logic             mem_state;
  logic             timed_out;
  logic [1:0]       imm_ext;
  logic [1:0]       imm_alu_op;
  state_t           decode_next;

  assign funct_ok = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

`ifdef CTRL_ZERO_EXT_EN
  assign zext_op = (opcode == OP_ANDI) || (opcode == OP_ORI);
`else
  assign zext_op = 1'b0;
`endif

  assign imm_ext    = (opcode == OP_LUI) ? 2'b10 : (zext_op ? 2'b01 : 2'b00);
  assign imm_alu_op = zext_op ? 2'b11 : 2'b00;

  // The access that waits for the MEM_TIMEOUT-th time without mem_ready gives up.
  assign mem_state = state inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign timed_out = mem_state && !mem_ready && (cnt == CNT_LAST);

  always_comb begin
    unique case (opcode)
      OP_RTYPE:     decode_next = funct_ok ? S_RTEX : S_HALT;
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_BEQ:       decode_next = S_BEQ;
      OP_J:         decode_next = S_JMP;
      OP_ADDI,
      OP_LUI:       decode_next = S_IEX;
      default:      decode_next = zext_op ? S_IEX : S_HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      cnt     <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state_next == S_HALT) fault_q <= 1'b1;
    end
  end

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: state_next = decode_next;
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      S_RTEX:   state_next = S_RTWB;
      S_RTWB:   state_next = S_FETCH;
      S_BEQ:    state_next = S_FETCH;
      S_JMP:    state_next = S_FETCH;
      S_IEX:    state_next = S_IWB;
      S_IWB:    state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_HALT;
    endcase
    // Counter only runs while a memory state is stalled; any progress clears it.
    if (mem_state && !mem_ready) begin
      if (timed_out)           state_next = S_HALT;
      else if (cnt != CNT_MAX) cnt_next   = cnt + CNT_W'(1);
      else                     cnt_next   = cnt;
    end
  end

  // Outputs are forced low during reset so an in-flight request drops immediately.
  always_comb begin
    pc_write    = 1'b0;
    pc_write_bz = 1'b0;
    pc_src      = 2'b00;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    ext_sel     = 2'b00;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_RTEX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_RTWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BEQ: begin
          alu_src_a   = 1'b1;
          alu_op      = 2'b01;
          pc_write_bz = 1'b1;
          pc_src      = 2'b01;
        end
        S_JMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        S_IEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = imm_alu_op;
          ext_sel   = imm_ext;
        end
        S_IWB: begin
          reg_write = 1'b1;
          ext_sel   = imm_ext;
        end
        default: ;
      endcase
    end
  end

  assign fault     = fault_q;
  assign state_dbg = state;

endmodule
